// File: rtl/sdram_clkgen_pkg.sv
// Shared types, default sizes and effective divide/phase helpers for sdram_clkgen.
package sdram_clkgen_pkg;

   typedef enum logic {SETTLE, RUN} state_t;

   localparam int DEF_DIV_W       = 16;
   localparam int DEF_LOCK_CYCLES = 1024;

   // Helpers work on a fixed 32-bit width; callers cast to/from DIV_W.
   localparam int FN_W = 32;

   function automatic logic [FN_W-1:0] n_eff(input logic [FN_W-1:0] div);
      return (div == '0) ? FN_W'(1) : div;
   endfunction

   function automatic logic [FN_W-1:0] phase_eff(input logic [FN_W-1:0] phase,
                                                input logic [FN_W-1:0] n);
      return (phase < n) ? phase : '0;
   endfunction

endpackage

// File: rtl/sdram_clkgen_ch.sv
// One clock-enable channel: shadow div/phase, wrap counter, ce decode.
// Optional sq square-wave qualifier when SDRAM_CLKGEN_SQUARE_EN is defined.
module sdram_clkgen_ch
   import sdram_clkgen_pkg::*;
#(
   parameter int DIV_W   = DEF_DIV_W,
   parameter int DEF_DIV = 1
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   input  logic [DIV_W-1:0] wr_phase,
   input  logic             load,
   input  logic             run,
   output logic             ce
`ifdef SDRAM_CLKGEN_SQUARE_EN
   ,
   output logic             sq
`endif
);

   logic [DIV_W-1:0] div_q, phase_q, cnt;
   logic [DIV_W-1:0] n_eff_w, ph_eff_w, last;

   assign n_eff_w  = DIV_W'(n_eff(FN_W'(div_q)));
   assign ph_eff_w = DIV_W'(phase_eff(FN_W'(phase_q), FN_W'(n_eff_w)));
   assign last     = n_eff_w - DIV_W'(1);

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= DIV_W'(DEF_DIV);
         phase_q <= '0;
      end else if (wr) begin
         div_q   <= wr_div;
         phase_q <= wr_phase;
      end
   end

   // Shadow only changes in RUN and forces a relock, so cnt < n_eff always holds.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= ph_eff_w;
      else if (run)
         cnt <= (cnt == last) ? '0 : cnt + DIV_W'(1);
   end

   assign ce = run && (cnt == last);

`ifdef SDRAM_CLKGEN_SQUARE_EN
   logic [DIV_W:0] half;
   assign half = ({1'b0, n_eff_w} + (DIV_W+1)'(1)) >> 1;
   assign sq   = run && ({1'b0, cnt} < half);
`endif

endmodule

// File: rtl/sdram_clkgen.sv
// Multi-channel clock-enable generator with settle/lock sequencer and cfg port.
// Define SDRAM_CLKGEN_SQUARE_EN to add the per-channel sq square-wave output.
module sdram_clkgen
   import sdram_clkgen_pkg::*;
#(
   parameter int NUM_CH      = 3,
   parameter int DIV_W       = DEF_DIV_W,
   parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
   parameter int DEF_DIV     = 1
) (
   input  logic                                      refclk,
   input  logic                                      rst_n,
   input  logic                                      cfg_valid,
   output logic                                      cfg_ready,
   input  logic [((NUM_CH>1)?$clog2(NUM_CH):1)-1:0]  cfg_ch,
   input  logic [DIV_W-1:0]                          cfg_div,
   input  logic [DIV_W-1:0]                          cfg_phase,
   output logic [NUM_CH-1:0]                         ce,
`ifdef SDRAM_CLKGEN_SQUARE_EN
   output logic [NUM_CH-1:0]                         sq,
`endif
   output logic                                      locked
);

   localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int              SW       = $clog2(LOCK_CYCLES);
   localparam logic [SW-1:0]   LAST     = SW'(LOCK_CYCLES - 1);
   localparam logic [CH_W:0]   NUM_CH_L = (CH_W+1)'(NUM_CH);

   state_t        state, state_nxt;
   logic [SW-1:0] settle_cnt, settle_nxt;
   logic          load, hs, in_range, cfg_wr;

   assign locked    = (state == RUN);
   assign cfg_ready = locked;
   assign hs        = cfg_valid && cfg_ready;
   assign in_range  = {1'b0, cfg_ch} < NUM_CH_L;
   assign cfg_wr    = hs && in_range;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SETTLE;
         settle_cnt <= '0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      settle_nxt = settle_cnt;
      load       = 1'b0;
      case (state)
         SETTLE: begin
            if (settle_cnt == LAST) begin
               settle_nxt = '0;
               load       = 1'b1;
               state_nxt  = RUN;
            end else begin
               settle_nxt = settle_cnt + SW'(1);
            end
         end
         RUN: begin
            // Out-of-range channel requests are swallowed without a relock.
            if (cfg_wr) begin
               state_nxt  = SETTLE;
               settle_nxt = '0;
            end
         end
         default: state_nxt = SETTLE;
      endcase
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sdram_clkgen_ch #(
         .DIV_W   (DIV_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .refclk   (refclk),
         .rst_n    (rst_n),
         .wr       (cfg_wr && (cfg_ch == CH_W'(i))),
         .wr_div   (cfg_div),
         .wr_phase (cfg_phase),
         .load     (load),
         .run      (locked),
         .ce       (ce[i])
`ifdef SDRAM_CLKGEN_SQUARE_EN
         ,
         .sq       (sq[i])
`endif
      );
   end

endmodule

// File: tb/tb_sdram_clkgen.sv
// Directed bench for sdram_clkgen: lock timing, ratios/phases, out-of-range cfg, async reset.
module tb_sdram_clkgen;

   localparam int NUM_CH = 3;
   localparam int DIV_W  = 16;
   localparam int LOCK   = 16;

   logic              refclk = 1'b0;
   logic              rst_n;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [1:0]        cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic [DIV_W-1:0]  cfg_phase;
   logic [NUM_CH-1:0] ce;
   logic              locked;
`ifdef SDRAM_CLKGEN_SQUARE_EN
   logic [NUM_CH-1:0] sq;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   sdram_clkgen #(
      .NUM_CH      (NUM_CH),
      .DIV_W       (DIV_W),
      .LOCK_CYCLES (LOCK),
      .DEF_DIV     (1)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .ce        (ce),
`ifdef SDRAM_CLKGEN_SQUARE_EN
      .sq        (sq),
`endif
      .locked    (locked)
   );

   always #5 refclk = ~refclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   // Ticks until locked reads 1; returns the tick count (100 means timeout).
   task automatic wait_lock(output int n);
      n = 0;
      while (!locked && n < 100) begin
         tick();
         n++;
      end
   endtask

   // Holds the request until accepted; returns in the cycle after the handshake.
   task automatic cfg(input int ch, input int div, input int ph);
      int n;
      n         = 0;
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_div   = DIV_W'(div);
      cfg_phase = DIV_W'(ph);
      while (!cfg_ready && n < 100) begin
         tick();
         n++;
      end
      check("cfg_accept_wait", 32'(n < 100), 32'd1);
      tick();
      cfg_valid = 1'b0;
   endtask

   // Bit k of each trace is the value in the k-th sampled cycle.
   task automatic trace(input int n, output logic [31:0] t0, output logic [31:0] t1,
                        output logic [31:0] t2, output logic [31:0] tsq, output logic lk_all);
      t0 = '0; t1 = '0; t2 = '0; tsq = '0; lk_all = 1'b1;
      for (int k = 0; k < n; k++) begin
         t0[k] = ce[0];
         t1[k] = ce[1];
         t2[k] = ce[2];
`ifdef SDRAM_CLKGEN_SQUARE_EN
         tsq[k] = sq[0];
`endif
         lk_all = lk_all & locked;
         tick();
      end
   endtask

   initial begin
      int          n;
      logic [31:0] t0, t1, t2, tsq;
      logic        lk;

      rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
      #22;
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_ready",  32'(cfg_ready), 32'd0);
      check("rst_ce",     32'(ce), 32'd0);
      @(negedge refclk);
      rst_n = 1'b1;
      #1;
      wait_lock(n);
      check("first_lock_cycles", 32'(n), 32'(LOCK));
      check("first_lock_ready",  32'(cfg_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         check("def_ce_all", 32'(ce), 32'h7);
         tick();
      end

      // ch0 div4 ph0, ch1 div4 ph3; second request is held through SETTLE
      cfg(0, 4, 0);
      check("hs_locked_drop", 32'(locked), 32'd0);
      check("hs_ready_drop",  32'(cfg_ready), 32'd0);
      cfg(1, 4, 3);
      wait_lock(n);
      check("relock_cycles", 32'(n), 32'(LOCK));
      trace(8, t0, t1, t2, tsq, lk);
      check("d4p0_ce0", t0, 32'h88);
      check("d4p3_ce1", t1, 32'h11);
      check("d1_ce2",   t2, 32'hFF);

      // div 0 acts as div 1, then div5 with phase 7 clamps to phase 0
      cfg(0, 0, 0);
      wait_lock(n);
      trace(8, t0, t1, t2, tsq, lk);
      check("d0_ce0", t0, 32'hFF);
      cfg(0, 5, 7);
      wait_lock(n);
      check("relock2_cycles", 32'(n), 32'(LOCK));
      trace(10, t0, t1, t2, tsq, lk);
      check("d5p7_ce0", t0, 32'h210);
      check("d4p3_ce1_b", t1, 32'h111);

      // out-of-range channel at T+10: strobes keep their T-relative phase
      cfg(3, 2, 1);
      check("oor_locked", 32'(locked), 32'd1);
      check("oor_ready",  32'(cfg_ready), 32'd1);
      trace(20, t0, t1, t2, tsq, lk);
      check("oor_ce0",    t0, 32'h42108);
      check("oor_ce1",    t1, 32'h22222);
      check("oor_ce2",    t2, 32'hFFFFF);
      check("oor_lk_all", 32'(lk), 32'd1);

      // async reset mid-RUN
      check("pre_rst_ce2", 32'(ce[2]), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_ce",     32'(ce), 32'd0);
      check("async_rst_locked", 32'(locked), 32'd0);
      check("async_rst_ready",  32'(cfg_ready), 32'd0);
      #1;
      rst_n = 1'b1;
      wait_lock(n);
      check("rst_relock_cycles", 32'(n), 32'(LOCK));
      trace(4, t0, t1, t2, tsq, lk);
      check("rst_def_ce0", t0, 32'hF);
      check("rst_def_ce1", t1, 32'hF);

`ifdef SDRAM_CLKGEN_SQUARE_EN
      cfg(0, 5, 0);
      wait_lock(n);
      trace(10, t0, t1, t2, tsq, lk);
      check("sq_d5_ce0", t0, 32'h210);
      check("sq_d5",     tsq, 32'hE7);
      cfg(0, 4, 0);
      wait_lock(n);
      trace(8, t0, t1, t2, tsq, lk);
      check("sq_d4", tsq, 32'h33);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
